// File: rtl/led_pattern_if.sv
// Pattern-generator control and LED drive bundle: mode/pause in, led/step out.
interface led_pattern_if #(
   parameter int unsigned NUM_LEDS = 6
);
   logic [1:0]          mode;
   logic                pause;
   logic [NUM_LEDS-1:0] led;
   logic                step;

   modport master (output mode, output pause, input led, input step);
   modport slave  (input mode, input pause, output led, output step);
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: exact-period prescaler driving binary, scan, breathing
// and alternate-flash patterns with pause, polarity select and step strobe.
module led_pattern_gen #(
   parameter int unsigned TICK_CYCLES   = 27000000,
   parameter int unsigned BREATH_CYCLES = 52734,
   parameter int unsigned NUM_LEDS      = 6,
   parameter int unsigned PWM_BITS      = 8,
   parameter bit          ACTIVE_LOW    = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   led_pattern_if.slave   bus
);

   function automatic logic [NUM_LEDS-1:0] even_bits();
      logic [NUM_LEDS-1:0] m;
      m = '0;
      for (int i = 0; i < int'(NUM_LEDS); i += 2) m[i] = 1'b1;
      return m;
   endfunction

   localparam int unsigned MAX_CYCLES = (TICK_CYCLES > BREATH_CYCLES) ? TICK_CYCLES : BREATH_CYCLES;
   localparam int unsigned PCNT_W     = $clog2(MAX_CYCLES);
   localparam int unsigned POS_W      = $clog2(NUM_LEDS);

   localparam logic [PCNT_W-1:0]   TICK_LAST   = PCNT_W'(TICK_CYCLES - 1);
   localparam logic [PCNT_W-1:0]   BREATH_LAST = PCNT_W'(BREATH_CYCLES - 1);
   localparam logic [POS_W-1:0]    POS_LAST    = POS_W'(NUM_LEDS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX    = '1;
   localparam logic [NUM_LEDS-1:0] POL_MASK    = {NUM_LEDS{ACTIVE_LOW}};
   localparam logic [NUM_LEDS-1:0] EVEN_MASK   = even_bits();

   typedef enum logic [1:0] {
      MODE_BINARY  = 2'd0,
      MODE_SCAN    = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_ALT     = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   mode_t               mode_q, mode_q_n;
   logic [PCNT_W-1:0]   pcnt, pcnt_n;
   logic [NUM_LEDS-1:0] count, count_n;
   logic [POS_W-1:0]    pos, pos_n;
   dir_t                scan_dir, scan_dir_n;
   logic [PWM_BITS-1:0] duty, duty_n;
   dir_t                duty_dir, duty_dir_n;
   logic                phase, phase_n;
   logic [PWM_BITS-1:0] pwm, pwm_n;
   logic                step_n;
   logic [NUM_LEDS-1:0] led_n;
   logic [NUM_LEDS-1:0] pattern;
   logic [PCNT_W-1:0]   tc_last;
   logic                mode_change;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q   <= mode_t'(bus.mode);
         pcnt     <= '0;
         count    <= '0;
         pos      <= '0;
         scan_dir <= DIR_UP;
         duty     <= '0;
         duty_dir <= DIR_UP;
         phase    <= 1'b0;
         pwm      <= '0;
         bus.step <= 1'b0;
         bus.led  <= POL_MASK;
      end else begin
         mode_q   <= mode_q_n;
         pcnt     <= pcnt_n;
         count    <= count_n;
         pos      <= pos_n;
         scan_dir <= scan_dir_n;
         duty     <= duty_n;
         duty_dir <= duty_dir_n;
         phase    <= phase_n;
         pwm      <= pwm_n;
         bus.step <= step_n;
         bus.led  <= led_n;
      end
   end

   always_comb begin
      mode_q_n    = mode_t'(bus.mode);
      pcnt_n      = pcnt;
      count_n     = count;
      pos_n       = pos;
      scan_dir_n  = scan_dir;
      duty_n      = duty;
      duty_dir_n  = duty_dir;
      phase_n     = phase;
      pwm_n       = pwm + PWM_BITS'(1);
      step_n      = 1'b0;
      pattern     = '0;
      mode_change = (mode_t'(bus.mode) != mode_q);
      tc_last     = (mode_q == MODE_BREATHE) ? BREATH_LAST : TICK_LAST;

      // A mode change restarts everything and suppresses a coincident step.
      if (mode_change) begin
         pcnt_n     = '0;
         count_n    = '0;
         pos_n      = '0;
         scan_dir_n = DIR_UP;
         duty_n     = '0;
         duty_dir_n = DIR_UP;
         phase_n    = 1'b0;
      end else if (!bus.pause) begin
         if (pcnt == tc_last) begin
            pcnt_n = '0;
            step_n = 1'b1;
            unique case (mode_q)
               MODE_BINARY: count_n = count + NUM_LEDS'(1);
               MODE_SCAN: begin
                  if (scan_dir == DIR_UP) begin
                     if (pos == POS_LAST) begin
                        scan_dir_n = DIR_DOWN;
                        pos_n      = pos - POS_W'(1);
                     end else begin
                        pos_n = pos + POS_W'(1);
                     end
                  end else begin
                     if (pos == '0) begin
                        scan_dir_n = DIR_UP;
                        pos_n      = pos + POS_W'(1);
                     end else begin
                        pos_n = pos - POS_W'(1);
                     end
                  end
               end
               MODE_BREATHE: begin
                  if (duty_dir == DIR_UP) begin
                     if (duty == DUTY_MAX) begin
                        duty_dir_n = DIR_DOWN;
                        duty_n     = duty - PWM_BITS'(1);
                     end else begin
                        duty_n = duty + PWM_BITS'(1);
                     end
                  end else begin
                     if (duty == '0) begin
                        duty_dir_n = DIR_UP;
                        duty_n     = duty + PWM_BITS'(1);
                     end else begin
                        duty_n = duty - PWM_BITS'(1);
                     end
                  end
               end
               MODE_ALT: phase_n = ~phase;
            endcase
         end else begin
            pcnt_n = pcnt + PCNT_W'(1);
         end
      end

      unique case (mode_q)
         MODE_BINARY:  pattern = count;
         MODE_SCAN:    pattern = NUM_LEDS'(1) << pos;
         MODE_BREATHE: pattern = {NUM_LEDS{pwm < duty}};
         MODE_ALT:     pattern = phase ? ~EVEN_MASK : EVEN_MASK;
      endcase
      led_n = pattern ^ POL_MASK;
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: scoreboard of expected step cycles and LED values
// (active-low binary/scan/alternate instance) plus PWM duty measurements.
module tb_led_pattern_gen;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   led_pattern_if #(.NUM_LEDS(4)) bus_a ();
   led_pattern_if #(.NUM_LEDS(4)) bus_b ();

   led_pattern_gen #(
      .TICK_CYCLES(4), .BREATH_CYCLES(2), .NUM_LEDS(4), .PWM_BITS(3), .ACTIVE_LOW(1'b1)
   ) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));

   led_pattern_gen #(
      .TICK_CYCLES(4), .BREATH_CYCLES(2), .NUM_LEDS(4), .PWM_BITS(3), .ACTIVE_LOW(1'b0)
   ) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

   typedef struct {
      int         cyc;
      logic [3:0] led;
   } exp_t;

   exp_t       sb_q[$];
   logic       pend = 1'b0;
   logic [3:0] pend_led = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic [3:0] l);
      exp_t e;
      e.cyc = c;
      e.led = l;
      sb_q.push_back(e);
   endtask

   task automatic go_to(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic at_neg(input int t);
      go_to(t);
      @(negedge clk);
   endtask

   // Monitor: every step pulse must match the next queued cycle; LED one cycle later.
   always @(negedge clk) begin
      exp_t e;
      if (pend) begin
         check("sb_led", 32'(bus_a.led), 32'(pend_led));
         pend = 1'b0;
      end
      if (bus_a.step === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_step: step at cycle %0d, none expected", cyc);
         end else begin
            e = sb_q.pop_front();
            check("sb_step_cycle", 32'(cyc), 32'(e.cyc));
            pend_led = e.led;
            pend     = 1'b1;
         end
      end
   end

   task automatic wait_step_b();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_b.step === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL b_step_timeout: no step within 20 cycles at cycle %0d", cyc);
      end
   endtask

   // Freeze duty with pause and count lit cycles over one full PWM period.
   task automatic measure(input string name, input int exp_lit);
      int lit;
      int steps;
      int odd;
      lit = 0; steps = 0; odd = 0;
      bus_b.pause = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus_b.led === 4'hF) lit++;
         else if (bus_b.led !== 4'h0) odd++;
         if (bus_b.step === 1'b1) steps++;
      end
      check(name, 32'(lit), 32'(exp_lit));
      check("b_led_uniform", 32'(odd), 32'd0);
      check("b_pause_nostep", 32'(steps), 32'd0);
      bus_b.pause = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0, c1, c2, c3, c4, k;
      logic [3:0] scan_led [7];
      logic [3:0] cnt;
      scan_led = '{4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101};

      bus_a.mode = 2'd0; bus_a.pause = 1'b0;
      bus_b.mode = 2'd2; bus_b.pause = 1'b1;

      // Reset state and binary count
      at_neg(3);
      check("a_reset_led", 32'(bus_a.led), 32'hF);
      check("a_reset_step", 32'(bus_a.step), 32'd0);
      go_to(4);
      rst_a = 1'b0;
      c0 = cyc;
      for (int j = 1; j <= 16; j++) begin
         cnt = 4'(j);
         push(c0 + 4 * j, ~cnt);
      end
      at_neg(c0 + 2);
      check("a_pre_step_led", 32'(bus_a.led), 32'hF);

      // Scan, entered by a mid-period mode change
      go_to(c0 + 66);
      bus_a.mode = 2'd1;
      c1 = cyc;
      for (int j = 0; j < 7; j++) push(c1 + 5 + 4 * j, scan_led[j]);
      at_neg(c1 + 2);
      check("a_scan_start_led", 32'(bus_a.led), 32'b1110);

      // Pause at pcnt=2 for 10 cycles in binary mode
      go_to(c1 + 31);
      bus_a.mode = 2'd0;
      c2 = cyc;
      push(c2 + 5, 4'b1110);
      push(c2 + 19, 4'b1101);
      push(c2 + 23, 4'b1100);
      go_to(c2 + 7);
      bus_a.pause = 1'b1;
      at_neg(c2 + 12);
      check("a_pause_led", 32'(bus_a.led), 32'b1110);
      check("a_pause_step", 32'(bus_a.step), 32'd0);
      go_to(c2 + 17);
      bus_a.pause = 1'b0;

      // Alternate flash after mid-period change 0 -> 3
      go_to(c2 + 25);
      bus_a.mode = 2'd3;
      c3 = cyc;
      push(c3 + 5, 4'b0101);
      push(c3 + 9, 4'b1010);
      push(c3 + 13, 4'b0101);
      push(c3 + 17, 4'b1010);
      at_neg(c3 + 2);
      check("a_alt_start_led", 32'(bus_a.led), 32'b1010);

      // Reset in the middle of a scan
      go_to(c3 + 19);
      bus_a.mode = 2'd1;
      c4 = cyc;
      push(c4 + 5, 4'b1101);
      push(c4 + 9, 4'b1011);
      go_to(c4 + 10);
      rst_a = 1'b1;
      go_to(c4 + 11);
      rst_a = 1'b0;
      push(c4 + 15, 4'b1101);
      push(c4 + 19, 4'b1011);
      at_neg(c4 + 11);
      check("a_midreset_led", 32'(bus_a.led), 32'hF);
      check("a_midreset_step", 32'(bus_a.step), 32'd0);
      at_neg(c4 + 12);
      check("a_post_reset_led", 32'(bus_a.led), 32'b1110);

      // Mode change on the same edge as a due step: change wins
      go_to(c4 + 22);
      bus_a.mode = 2'd0;
      push(c4 + 27, 4'b1110);
      go_to(c4 + 30);
      check("a_sb_drain", 32'(sb_q.size()), 32'd0);
      bus_a.pause = 1'b1;

      // Breathing instance: duty 0 after reset, then sampled along 0..7..0
      at_neg(cyc + 1);
      check("b_reset_led", 32'(bus_b.led), 32'h0);
      check("b_reset_step", 32'(bus_b.step), 32'd0);
      go_to(cyc + 1);
      rst_b = 1'b0;
      measure("b_duty0_reset", 0);
      k = 0;
      while (k < 15) begin
         wait_step_b();
         k++;
         case (k)
            3:  measure("b_duty3_up", 3);
            7:  measure("b_duty7_top", 7);
            8:  measure("b_duty6_down", 6);
            14: measure("b_duty0_bottom", 0);
            15: measure("b_duty1_up", 1);
            default: ;
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
